// File: rtl/alu_mdu_pkg.sv
// Shared types and op-decoding helpers for the ALU with iterative multiply/divide.
package alu_mdu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLT    = 5'd2,
    ALU_SLTU   = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_OR     = 5'd5,
    ALU_AND    = 5'd6,
    ALU_SLL    = 5'd7,
    ALU_SRL    = 5'd8,
    ALU_SRA    = 5'd9,
    ALU_PASS_B = 5'd15,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Multiply family runs through the shift-add loop.
  function automatic logic is_mul(alu_op_e op);
    case (op)
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  // Divide/remainder family runs through the restoring-division loop.
  function automatic logic is_div(alu_op_e op);
    case (op)
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  // Remainder ops return the remainder instead of the quotient.
  function automatic logic is_rem(alu_op_e op);
    return (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  // Operand A is interpreted as two's complement.
  function automatic logic op_signed_a(alu_op_e op);
    case (op)
      ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  // Operand B is interpreted as two's complement.
  function automatic logic op_signed_b(alu_op_e op);
    case (op)
      ALU_MULH, ALU_DIV, ALU_REM: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle integer ALU, XLEN wide.
module alu_core
  import alu_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_e           op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   y
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;

  assign shamt = b[SHW-1:0];

  // Basic-op result; multiply/divide and unused codes yield zero.
  always_comb begin
    // NOTE: y gets a default before the case so no path leaves it unassigned and no latch is inferred.
    y = '0;
    case (op)
      ALU_ADD:    y = a + b;
      ALU_SUB:    y = a - b;
      ALU_SLT:    y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:   y = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:    y = a ^ b;
      ALU_OR:     y = a | b;
      ALU_AND:    y = a & b;
      ALU_SLL:    y = a << shamt;
      ALU_SRL:    y = a >> shamt;
      ALU_SRA:    y = XLEN'($signed(a) >>> shamt);
      ALU_PASS_B: y = b;
      default:    y = '0;
    endcase
  end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with iterative RV32M-style multiply/divide and valid/ready handshake.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [4:0]        i_alu_op,
  input  logic [XLEN-1:0]   i_operand_a,
  input  logic [XLEN-1:0]   i_operand_b,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [XLEN-1:0]   o_alu_data
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_e             state;
  alu_op_e            op_q;
  logic [CW-1:0]      count;
  logic [XLEN-1:0]    opnd_q;     // multiplicand magnitude or divisor magnitude
  logic [2*XLEN-1:0]  acc;        // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic               neg_q;      // negate product / quotient at the end
  logic               neg_r;      // negate remainder at the end

  alu_op_e            op_in;
  logic [XLEN-1:0]    core_y;
  logic               sa_in;
  logic               sb_in;
  logic [XLEN-1:0]    mag_a;
  logic [XLEN-1:0]    mag_b;
  logic               div_zero;
  logic               div_ovf;
  logic [XLEN-1:0]    div_special_y;
  logic               last_iter;

  logic [XLEN:0]      mul_sum;
  logic [2*XLEN-1:0]  mul_next;
  logic [2*XLEN-1:0]  mul_prod;
  logic [XLEN-1:0]    mul_y;

  logic [XLEN:0]      div_shift;
  logic [XLEN:0]      div_trial;
  logic [2*XLEN-1:0]  div_next;
  logic [XLEN-1:0]    div_q;
  logic [XLEN-1:0]    div_r;
  logic [XLEN-1:0]    div_y;

  assign op_in     = alu_op_e'(i_alu_op);
  assign o_ready   = (state == ST_IDLE);
  assign last_iter = (count == CW'(XLEN - 1));

  alu_core #(.XLEN(XLEN)) u_core (
    .op (op_in),
    .a  (i_operand_a),
    .b  (i_operand_b),
    .y  (core_y)
  );

  // Operand preparation at accept: magnitudes and divide special cases.
  always_comb begin
    sa_in    = op_signed_a(op_in);
    sb_in    = op_signed_b(op_in);
    mag_a    = (sa_in && i_operand_a[XLEN-1]) ? -i_operand_a : i_operand_a;
    mag_b    = (sb_in && i_operand_b[XLEN-1]) ? -i_operand_b : i_operand_b;
    div_zero = (i_operand_b == '0);
    div_ovf  = sa_in && (i_operand_a == MIN_VAL) && (i_operand_b == '1);
    if (div_zero) begin
      div_special_y = is_rem(op_in) ? i_operand_a : '1;
    end else begin
      div_special_y = is_rem(op_in) ? '0 : MIN_VAL;
    end
  end

  // One shift-add multiply step plus final sign fix and half selection.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd_q : {XLEN{1'b0}})};
    mul_next = {mul_sum, acc[XLEN-1:1]};
    mul_prod = neg_q ? -mul_next : mul_next;
    mul_y    = (op_q == ALU_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
  end

  // One restoring-division step plus final sign fix and result selection.
  always_comb begin
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    if (!div_trial[XLEN]) begin
      div_next = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      div_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
    div_q = neg_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
    div_r = neg_r ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
    div_y = is_rem(op_q) ? div_r : div_q;
  end

  // Control FSM with registered result and valid; flush overrides everything.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: all state and datapath registers use non-blocking assignments and are cleared by reset.
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      op_q       <= ALU_ADD;
      count      <= '0;
      opnd_q     <= '0;
      acc        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      o_valid    <= 1'b0;
      o_alu_data <= '0;
    end else if (i_flush) begin
      state      <= ST_IDLE;
      o_valid    <= 1'b0;
      o_alu_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            op_q  <= op_in;
            count <= '0;
            if (is_mul(op_in)) begin
              opnd_q <= mag_a;
              acc    <= {{XLEN{1'b0}}, mag_b};
              neg_q  <= (sa_in && i_operand_a[XLEN-1]) ^ (sb_in && i_operand_b[XLEN-1]);
              neg_r  <= 1'b0;
              state  <= ST_MUL;
            end else if (is_div(op_in)) begin
              if (div_zero || div_ovf) begin
                o_alu_data <= div_special_y;
                o_valid    <= 1'b1;
                state      <= ST_DONE;
              end else begin
                opnd_q <= mag_b;
                acc    <= {{XLEN{1'b0}}, mag_a};
                neg_q  <= sa_in && (i_operand_a[XLEN-1] ^ i_operand_b[XLEN-1]);
                neg_r  <= sa_in && i_operand_a[XLEN-1];
                state  <= ST_DIV;
              end
            end else begin
              o_alu_data <= core_y;
              o_valid    <= 1'b1;
              state      <= ST_DONE;
            end
          end
        end
        ST_MUL: begin
          acc   <= mul_next;
          count <= count + 1'b1;
          if (last_iter) begin
            o_alu_data <= mul_y;
            o_valid    <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DIV: begin
          acc   <= div_next;
          count <= count + 1'b1;
          if (last_iter) begin
            o_alu_data <= div_y;
            o_valid    <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu at XLEN=32 and XLEN=16 against an arithmetic reference model.
module tb_alu_mdu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  logic        valid32 = 1'b0, rdy_in32 = 1'b1, rdy_out32, ovalid32;
  logic [4:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0, data32;

  logic        valid16 = 1'b0, rdy_in16 = 1'b1, rdy_out16, ovalid16;
  logic [4:0]  op16 = '0;
  logic [15:0] a16 = '0, b16 = '0, data16;

  int checks = 0;
  int errors = 0;

  alu_mdu #(.XLEN(32)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid32), .o_ready(rdy_out32),
    .i_alu_op(op32), .i_operand_a(a32), .i_operand_b(b32), .o_valid(ovalid32),
    .i_ready(rdy_in32), .o_alu_data(data32)
  );

  alu_mdu #(.XLEN(16)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid16), .o_ready(rdy_out16),
    .i_alu_op(op16), .i_operand_a(a16), .i_operand_b(b16), .o_valid(ovalid16),
    .i_ready(rdy_in16), .o_alu_data(data16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (w == 32) begin
      valid32 = v; op32 = op; a32 = a; b32 = b;
    end else begin
      valid16 = v; op16 = op; a16 = a[15:0]; b16 = b[15:0];
    end
  endtask

  task automatic set_rdy(input int w, input logic r);
    if (w == 32) rdy_in32 = r;
    else         rdy_in16 = r;
  endtask

  function automatic logic out_valid(input int w);
    return (w == 32) ? ovalid32 : ovalid16;
  endfunction

  function automatic logic out_ready(input int w);
    return (w == 32) ? rdy_out32 : rdy_out16;
  endfunction

  function automatic logic [31:0] out_data(input int w);
    return (w == 32) ? data32 : {16'h0, data16};
  endfunction

  // Reference model: plain integer arithmetic on 64-bit values, truncated to w bits.
  function automatic logic [31:0] model(input int w, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mask;
    longint      sa, sb, ua, ub, min_v, r;
    logic [63:0] p;
    int          sh;
    mask  = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    sa    = (w == 32) ? longint'($signed(a)) : longint'($signed(a[15:0]));
    sb    = (w == 32) ? longint'($signed(b)) : longint'($signed(b[15:0]));
    ua    = longint'(a & mask);
    ub    = longint'(b & mask);
    min_v = -(longint'(1) << (w - 1));
    sh    = int'(ub % longint'(w));
    case (op)
      5'd0:  r = ua + ub;
      5'd1:  r = ua - ub;
      5'd2:  r = (sa < sb) ? 1 : 0;
      5'd3:  r = (ua < ub) ? 1 : 0;
      5'd4:  r = ua ^ ub;
      5'd5:  r = ua | ub;
      5'd6:  r = ua & ub;
      5'd7:  r = ua << sh;
      5'd8:  r = ua >> sh;
      5'd9:  r = sa >>> sh;
      5'd15: r = ub;
      5'd16: begin p = 64'(sa * sb); r = longint'(p); end
      5'd17: begin p = 64'(sa * sb); r = longint'(p >> w); end
      5'd18: begin p = 64'(sa * ub); r = longint'(p >> w); end
      5'd19: begin p = 64'(ua * ub); r = longint'(p >> w); end
      5'd20: r = (ub == 0) ? -1 : (sa == min_v && sb == -1) ? min_v : sa / sb;
      5'd21: r = (ub == 0) ? -1 : ua / ub;
      5'd22: r = (ub == 0) ? sa : (sa == min_v && sb == -1) ? 0 : sa % sb;
      5'd23: r = (ub == 0) ? ua : ua % ub;
      default: r = 0;
    endcase
    return 32'(r) & mask;
  endfunction

  // Expected cycles from the accept edge to o_valid high.
  function automatic int exp_lat(input int w, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mask, min_v;
    mask  = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    min_v = (w == 32) ? 32'h8000_0000 : 32'h0000_8000;
    if (op >= 5'd16 && op <= 5'd19) return w + 1;
    if (op >= 5'd20 && op <= 5'd23) begin
      if ((b & mask) == 0) return 1;
      if ((op == 5'd20 || op == 5'd22) && (a & mask) == min_v && (b & mask) == mask) return 1;
      return w + 1;
    end
    return 1;
  endfunction

  task automatic run_op(input int w, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    int lat;
    @(negedge clk);
    check({tag, "/ready"}, 64'(out_ready(w)), 64'd1);
    drive(w, 1'b1, op, a, b);
    @(posedge clk); #1;
    drive(w, 1'b0, 5'($urandom), $urandom, $urandom);
    lat = 1;
    while (!out_valid(w) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/lat"}, 64'(lat), 64'(exp_lat(w, op, a, b)));
    check({tag, "/data"}, 64'(out_data(w)), 64'(exp));
    @(posedge clk); #1;
    check({tag, "/release"}, {62'd0, out_valid(w), out_ready(w)}, 64'b01);
  endtask

  function automatic logic [31:0] pick_operand(input int w);
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return (w == 32) ? 32'h8000_0000 : 32'h0000_8000;
      3:       return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  int unsigned op_list[] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 15, 16, 17, 18, 19, 20, 21, 22, 23, 10, 31};

  initial begin
    // Reset values
    #12;
    check("reset/ready32", 64'(rdy_out32), 64'd1);
    check("reset/valid32", 64'(ovalid32), 64'd0);
    check("reset/data32", 64'(data32), 64'd0);
    check("reset/ready16", 64'(rdy_out16), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases, 32-bit
    run_op(32, 5'd0,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, "add_ovf");
    run_op(32, 5'd9,  32'h8000_0000, 32'd31,        32'hFFFF_FFFF, "sra31");
    run_op(32, 5'd17, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, "mulh");
    run_op(32, 5'd16, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFA, "mul");
    run_op(32, 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
    run_op(32, 5'd20, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_neg");
    run_op(32, 5'd22, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_neg");
    run_op(32, 5'd21, 32'd100,       32'd7,         32'd14,        "divu");
    run_op(32, 5'd20, 32'd5,         32'd0,         32'hFFFF_FFFF, "div_zero");
    run_op(32, 5'd23, 32'd5,         32'd0,         32'd5,         "remu_zero");
    run_op(32, 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    run_op(32, 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         "rem_ovf");
    run_op(32, 5'd10, 32'h1234_5678, 32'h1,         32'h0,         "bad_op");

    // Directed cases, 16-bit
    run_op(16, 5'd17, 32'hFFFE, 32'd3,  32'hFFFF, "mulh16");
    run_op(16, 5'd16, 32'hFFFE, 32'd3,  32'hFFFA, "mul16");
    run_op(16, 5'd20, 32'hFFF9, 32'd2,  32'hFFFD, "div16");
    run_op(16, 5'd22, 32'hFFF9, 32'd2,  32'hFFFF, "rem16");
    run_op(16, 5'd21, 32'd100,  32'd7,  32'd14,   "divu16");

    // Randomized ops against the model
    for (int i = 0; i < 60; i++) begin
      int w;
      logic [4:0] op;
      logic [31:0] a, b;
      w  = (i % 3 == 2) ? 16 : 32;
      op = 5'(op_list[$urandom_range(0, op_list.size() - 1)]);
      a  = pick_operand(w);
      b  = pick_operand(w);
      run_op(w, op, a, b, model(w, op, a, b), $sformatf("rnd%0d_op%0d_w%0d", i, op, w));
    end

    // Backpressure: result held while operands toggle
    begin
      int lat;
      @(negedge clk);
      set_rdy(32, 1'b0);
      drive(32, 1'b1, 5'd21, 32'd100, 32'd7);
      @(posedge clk); #1;
      drive(32, 1'b0, 5'd0, 32'h0, 32'h0);
      lat = 1;
      while (!ovalid32 && lat < 100) begin
        @(posedge clk); #1;
        lat++;
      end
      check("bp/lat", 64'(lat), 64'd33);
      for (int k = 0; k < 5; k++) begin
        drive(32, 1'b1, 5'($urandom), $urandom, $urandom);
        @(posedge clk); #1;
        check($sformatf("bp/hold%0d", k), {31'd0, ovalid32, rdy_out32, data32}, {31'd0, 1'b1, 1'b0, 32'd14});
      end
      drive(32, 1'b0, 5'd0, 32'h0, 32'h0);
      set_rdy(32, 1'b1);
      @(posedge clk); #1;
      check("bp/release", {62'd0, ovalid32, rdy_out32}, 64'b01);
    end

    // Flush at cycle N+10 of a DIV: result never appears
    begin
      logic seen;
      seen = 1'b0;
      @(negedge clk);
      drive(32, 1'b1, 5'd20, 32'd1000, 32'd3);
      @(posedge clk); #1;
      drive(32, 1'b0, 5'd0, 32'h0, 32'h0);
      for (int k = 0; k < 9; k++) begin
        seen |= ovalid32;
        @(posedge clk); #1;
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush/idle", {62'd0, ovalid32, rdy_out32}, 64'b01);
      for (int k = 0; k < 40; k++) begin
        seen |= ovalid32;
        @(posedge clk); #1;
      end
      check("flush/never_valid", 64'(seen), 64'd0);
    end

    // Request coinciding with flush is not accepted
    @(negedge clk);
    drive(32, 1'b1, 5'd0, 32'd1, 32'd2);
    flush = 1'b1;
    @(posedge clk); #1;
    drive(32, 1'b0, 5'd0, 32'h0, 32'h0);
    flush = 1'b0;
    check("flush/no_accept", {62'd0, ovalid32, rdy_out32}, 64'b01);

    // Asynchronous reset mid-MUL
    @(negedge clk);
    drive(32, 1'b1, 5'd16, 32'd12345, 32'd678);
    @(posedge clk); #1;
    drive(32, 1'b0, 5'd0, 32'h0, 32'h0);
    repeat (5) @(posedge clk);
    #2;
    check("arst/busy", 64'(rdy_out32), 64'd0);
    rst_n = 1'b0;
    #1;
    check("arst/mul", {31'd0, ovalid32, rdy_out32, data32}, {31'd0, 1'b0, 1'b1, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset while a result is held
    @(negedge clk);
    set_rdy(32, 1'b0);
    drive(32, 1'b1, 5'd0, 32'd40, 32'd2);
    @(posedge clk); #1;
    drive(32, 1'b0, 5'd0, 32'h0, 32'h0);
    check("arst/pre", {31'd0, ovalid32, rdy_out32, data32}, {31'd0, 1'b1, 1'b0, 32'd42});
    #2;
    rst_n = 1'b0;
    #1;
    check("arst/done", {31'd0, ovalid32, rdy_out32, data32}, {31'd0, 1'b0, 1'b1, 32'd0});
    set_rdy(32, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
Parametrised, handshaked successor to the single-cycle integer ALU. It adds the RV32M multiply/divide family to the existing ALU operations. Basic operations complete in one registered cycle; multiply and divide run iteratively, one bit per cycle. The block sits in the execute stage and stalls the pipeline through a valid/ready handshake.

Parameters:
XLEN, 32, operand/result width; must be a power of two, at least 8.
SHW, $clog2(XLEN), shift-amount width (derived; not overridable).

Ports:
i_clk  input  1  clock, rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_flush  input  1  synchronous abort of any operation in flight.
i_valid  input  1  request valid.
o_ready  output  1  block can accept a request (high only in IDLE).
i_alu_op  input  5  operation code (see Behaviour).
i_operand_a  input  XLEN  first operand.
i_operand_b  input  XLEN  second operand / shift amount.
o_valid  output  1  result valid.
i_ready  input  1  consumer accepts result.
o_alu_data  output  XLEN  result, held stable while o_valid && !i_ready.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - State goes to IDLE.
  - o_valid=0, o_ready=1 (combinational from IDLE), o_alu_data=0.
  - All datapath registers cleared.
- Op codes:
  - 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 XOR, 5 OR, 6 AND, 7 SLL, 8 SRL, 9 SRA, 15 PASS_B (result = operand_b).
  - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - Any other code returns 0 with basic-op latency.
- SLT/SLTU result is zero-extended 0/1. Shifts use operand_b[SHW-1:0]. SRA replicates operand_a[XLEN-1].
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: accept a request when i_valid && o_ready (cycle N); operands and op are captured.
    - Basic op: result is computed combinationally, registered, and the FSM goes to DONE. o_valid is high at N+1.
    - MUL*: operands are converted to magnitudes per signedness (MULH: both signed; MULHSU: a signed, b unsigned); the sign flag is stored; the FSM goes to MUL.
    - DIV*/REM*: magnitudes and sign flags are stored; the FSM goes to DIV.
    - DIV*/REM* special cases skip DIV and go straight to DONE, with o_valid at N+1:
      - Divisor zero: quotient = all ones; remainder = dividend.
      - Signed overflow (a = most-negative, b = -1): quotient = most-negative; remainder = 0.
  - MUL: shift-add, one multiplier bit per cycle, XLEN cycles, into a 2*XLEN accumulator. On the last iteration the product is negated if the sign flag is set, then the FSM goes to DONE.
    - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
    - o_valid is high at N+XLEN+1.
  - DIV: restoring division, one quotient bit per cycle, XLEN cycles. After the last iteration:
    - Quotient is negated if the operand signs differ (signed ops only).
    - Remainder takes the sign of the dividend.
    - The FSM goes to DONE; o_valid is high at N+XLEN+1.
  - DONE: o_valid=1 and o_alu_data is held. When i_ready is high, the FSM goes to IDLE next cycle with o_valid=0. No new request is accepted in the same cycle as result acceptance.
- Iteration counter is SHW+1 bits. It is loaded on accept and the final iteration is detected at count == XLEN-1.
- i_flush has priority over every transition. In any state it forces IDLE on the next edge with o_valid=0 and discards the result. A request presented in the same cycle as i_flush is not accepted.
- Operand and op changes while the FSM is not in IDLE are ignored (captured copies only).
- Maximum throughput: basic op every 2 cycles; mul/div every XLEN+2 cycles.

Decomposition:
- Package alu_mdu_pkg:
  - alu_op_e enum with the codes above.
  - state_e enum.
  - Helper functions is_mul(op), is_div(op), op_signed_a(op), op_signed_b(op).
- One sub-module, alu_core: the combinational basic-op ALU generalised to XLEN, with the same op encoding. alu_mdu instantiates alu_core and adds the FSM and the mul/div datapath.

Test Plan:
1. ADD 0x7FFFFFFF+1 with i_ready=1 -> o_valid at N+1, o_alu_data=0x80000000, o_ready high again at N+2. SRA 0x80000000 by 31 -> 0xFFFFFFFF.
2. MULH a=-2 (0xFFFFFFFE), b=3 -> o_valid exactly at N+33, data=0xFFFFFFFF. MUL same operands -> 0xFFFFFFFA. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
3. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14 at N+33.
4. DIV 5/0 -> 0xFFFFFFFF at N+1; REMU 5/0 -> 5. DIV 0x80000000/-1 -> 0x80000000 at N+1; REM of the same operands -> 0.
5. Backpressure: result valid with i_ready=0 for 5 cycles, with operands toggled meanwhile -> o_alu_data stable and o_ready=0 throughout. i_ready=1 -> o_valid low next cycle.
6. Flush and reset mid-operation:
   - i_flush at cycle N+10 of a DIV -> IDLE at N+11, o_valid never asserted.
   - Async i_rst_n low mid-MUL -> outputs reset immediately without waiting for a clock edge.
   - Parameter sweep: repeat scenarios 2-3 with XLEN=16 -> latency 17.
